// File: rtl/memory_port_arbiter.sv
// rtl/memory_port_arbiter.sv - shares the MemoryUnit port between instruction fetch and data load/store
// Build option: ARBITER_ROUND_ROBIN_EN selects alternating grants instead of data priority with a starvation guard.
module memory_port_arbiter #(
    parameter int ADDR_WIDTH        = 32,
    parameter int DATA_WIDTH        = 32,
    parameter int INSTRUCTION_WIDTH = 16,
    parameter int MEM_LATENCY       = 2,
    parameter int STARVE_LIMIT      = 4
) (
    input  logic                         fast_clock,
    input  logic                         reset,
    input  logic                         fetch_req,
    input  logic [ADDR_WIDTH-1:0]        fetch_addr,
    output logic                         fetch_ready,
    output logic                         fetch_valid,
    output logic [INSTRUCTION_WIDTH-1:0] fetch_data,
    input  logic                         data_req,
    input  logic                         data_write,
    input  logic [ADDR_WIDTH-1:0]        data_addr,
    input  logic [DATA_WIDTH-1:0]        data_wdata,
    output logic                         data_ready,
    output logic                         data_valid,
    output logic [DATA_WIDTH-1:0]        data_rdata,
    output logic [ADDR_WIDTH-1:0]        mem_addr,
    output logic [DATA_WIDTH-1:0]        mem_wdata,
    output logic                         mem_write,
    input  logic [DATA_WIDTH-1:0]        mem_rdata,
    output logic                         busy,
    output logic                         grant_owner
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [3:0] lat_cnt;
    logic       write_op;
    logic       half_sel;
    logic       grant;
    logic       capture;
    logic       pick_data;

`ifdef ARBITER_ROUND_ROBIN_EN
    // Under contention the requester that did not own the last access wins.
    assign pick_data = data_req && (!fetch_req || !grant_owner);
`else
    logic [3:0] starve_cnt;

    assign pick_data = data_req && !(fetch_req && (starve_cnt >= 4'(STARVE_LIMIT)));

    always_ff @(posedge fast_clock or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (grant) begin
            if (!pick_data) begin
                starve_cnt <= '0;
            end else if (fetch_req && (starve_cnt != 4'hF)) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end
`endif

    always_ff @(posedge fast_clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        grant      = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (fetch_req || data_req) begin
                    grant      = 1'b1;
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                if (lat_cnt <= 4'd1) begin
                    capture    = 1'b1;
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge fast_clock or posedge reset) begin
        if (reset) begin
            fetch_ready <= 1'b0;
            fetch_valid <= 1'b0;
            fetch_data  <= '0;
            data_ready  <= 1'b0;
            data_valid  <= 1'b0;
            data_rdata  <= '0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_write   <= 1'b0;
            grant_owner <= 1'b0;
            lat_cnt     <= '0;
            write_op    <= 1'b0;
            half_sel    <= 1'b0;
        end else begin
            fetch_ready <= 1'b0;
            data_ready  <= 1'b0;
            fetch_valid <= 1'b0;
            data_valid  <= 1'b0;
            mem_write   <= 1'b0;
            if (grant) begin
                grant_owner <= pick_data;
                lat_cnt     <= 4'(MEM_LATENCY);
                if (pick_data) begin
                    mem_addr   <= data_addr;
                    mem_wdata  <= data_wdata;
                    mem_write  <= data_write;
                    write_op   <= data_write;
                    data_ready <= 1'b1;
                end else begin
                    mem_addr    <= fetch_addr;
                    write_op    <= 1'b0;
                    half_sel    <= fetch_addr[1];
                    fetch_ready <= 1'b1;
                end
            end else if (capture) begin
                lat_cnt <= '0;
                if (grant_owner) begin
                    data_valid <= 1'b1;
                    if (!write_op) begin
                        data_rdata <= mem_rdata;
                    end
                end else begin
                    fetch_valid <= 1'b1;
                    fetch_data  <= half_sel ? mem_rdata[2*INSTRUCTION_WIDTH-1:INSTRUCTION_WIDTH]
                                            : mem_rdata[INSTRUCTION_WIDTH-1:0];
                end
            end else if (state == ACCESS) begin
                lat_cnt <= lat_cnt - 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_memory_port_arbiter.sv
// tb/tb_memory_port_arbiter.sv - scoreboard bench for memory_port_arbiter
module tb_memory_port_arbiter;
    localparam int L      = 2;
    localparam int SL     = 3;
    localparam int N_RAND = 150;

    logic        fast_clock = 1'b0;
    logic        reset;
    logic        fetch_req, fetch_ready, fetch_valid;
    logic [31:0] fetch_addr;
    logic [15:0] fetch_data;
    logic        data_req, data_write, data_ready, data_valid;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_write, busy, grant_owner;

    always #5 fast_clock = ~fast_clock;

    memory_port_arbiter #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .INSTRUCTION_WIDTH(16),
        .MEM_LATENCY(L), .STARVE_LIMIT(SL)
    ) dut (
        .fast_clock(fast_clock), .reset(reset),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
        .fetch_valid(fetch_valid), .fetch_data(fetch_data),
        .data_req(data_req), .data_write(data_write), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_ready(data_ready), .data_valid(data_valid),
        .data_rdata(data_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_write(mem_write), .mem_rdata(mem_rdata), .busy(busy), .grant_owner(grant_owner)
    );

    function automatic logic [31:0] init_word(input logic [10:0] idx);
        return ({21'h0, idx} * 32'h9E3779B1) ^ 32'h5A5A00C3;
    endfunction

    // Memory responder: one-cycle registered read, written by the DUT's store strobe.
    bit [31:0] resp_mem [0:2047];
    bit        resp_wr  [0:2047];
    always @(posedge fast_clock) begin
        if (mem_write) begin
            resp_mem[mem_addr[12:2]] <= mem_wdata;
            resp_wr[mem_addr[12:2]]  <= 1'b1;
        end
        mem_rdata <= resp_wr[mem_addr[12:2]] ? resp_mem[mem_addr[12:2]] : init_word(mem_addr[12:2]);
    end

    // Reference memory contents, updated in data-path issue order.
    bit [31:0] ref_mem [0:2047];
    bit        ref_wr  [0:2047];
    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_wr[a[12:2]] ? ref_mem[a[12:2]] : init_word(a[12:2]);
    endfunction

    typedef struct {
        bit          is_write;
        logic [31:0] rdata;
    } dexp_t;

    logic [15:0] fetch_q[$];
    dexp_t       data_q[$];
    int          glog_owner[$];
    int          glog_cyc[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic outs_any();
        return |{fetch_ready, fetch_valid, fetch_data, data_ready, data_valid, data_rdata,
                 mem_addr, mem_wdata, mem_write, busy, grant_owner};
    endfunction

    // Monitor / reference model state
    int          last_ready = -100;
    bit          last_owner_d, last_write;
    logic [31:0] last_addr, last_wdata;
    bit          prev_f, prev_d, prev_dw;
    logic [31:0] prev_fa, prev_da, prev_wd;
    logic [31:0] m_rdata = 32'h0;
    bit          exp_rdy, win, in_busy, resp_cyc;
    logic [15:0] fexp;
    dexp_t       dexp;
`ifdef ARBITER_ROUND_ROBIN_EN
    bit          m_owner = 1'b0;
`else
    int          m_starve = 0;
`endif

    always @(negedge fast_clock) begin
        cyc++;
        if (reset) begin
            check(outs_any() == 1'b0, "reset_outputs", {31'h0, outs_any()}, 32'h0);
            fetch_q.delete();
            data_q.delete();
            last_ready = -100;
            prev_f = 1'b0;
            prev_d = 1'b0;
            m_rdata = 32'h0;
`ifdef ARBITER_ROUND_ROBIN_EN
            m_owner = 1'b0;
`else
            m_starve = 0;
`endif
        end else begin
            exp_rdy = (prev_f || prev_d) && (cyc - 1 >= last_ready + L + 1);
            check((fetch_ready || data_ready) == exp_rdy, "ready_timing",
                  {30'h0, fetch_ready, data_ready}, {31'h0, exp_rdy});
            if (exp_rdy && (fetch_ready || data_ready)) begin
`ifdef ARBITER_ROUND_ROBIN_EN
                win = prev_d && (!prev_f || !m_owner);
                m_owner = win;
`else
                win = prev_d && !(prev_f && m_starve >= SL);
                if (!win) m_starve = 0;
                else if (prev_f && m_starve < 15) m_starve++;
`endif
                check(data_ready == win && fetch_ready == !win, "winner",
                      {30'h0, fetch_ready, data_ready}, {30'h0, !win, win});
                check(grant_owner == win, "grant_owner", {31'h0, grant_owner}, {31'h0, win});
                last_ready   = cyc;
                last_owner_d = win;
                last_write   = win && prev_dw;
                last_addr    = win ? prev_da : prev_fa;
                last_wdata   = prev_wd;
                glog_owner.push_back(int'(win));
                glog_cyc.push_back(cyc);
            end
            in_busy = (cyc >= last_ready) && (cyc <= last_ready + L);
            check(busy == in_busy, "busy", {31'h0, busy}, {31'h0, in_busy});
            if (in_busy) check(mem_addr == last_addr, "mem_addr", mem_addr, last_addr);
            check(mem_write == (cyc == last_ready && last_write), "mem_write",
                  {31'h0, mem_write}, {31'h0, (cyc == last_ready && last_write)});
            if (mem_write) check(mem_wdata == last_wdata, "mem_wdata", mem_wdata, last_wdata);
            resp_cyc = (cyc == last_ready + L);
            check(fetch_valid == (resp_cyc && !last_owner_d), "fetch_valid",
                  {31'h0, fetch_valid}, {31'h0, (resp_cyc && !last_owner_d)});
            check(data_valid == (resp_cyc && last_owner_d), "data_valid",
                  {31'h0, data_valid}, {31'h0, (resp_cyc && last_owner_d)});
            if (fetch_valid) begin
                check(fetch_q.size() != 0, "fetch_unexpected", fetch_q.size(), 1);
                if (fetch_q.size() != 0) begin
                    fexp = fetch_q.pop_front();
                    check(fetch_data == fexp, "fetch_data", {16'h0, fetch_data}, {16'h0, fexp});
                end
            end
            if (data_valid) begin
                check(data_q.size() != 0, "data_unexpected", data_q.size(), 1);
                if (data_q.size() != 0) begin
                    dexp = data_q.pop_front();
                    if (!dexp.is_write) m_rdata = dexp.rdata;
                    check(data_rdata == m_rdata, "data_rdata", data_rdata, m_rdata);
                end
            end
            prev_f  = fetch_req;
            prev_d  = data_req;
            prev_dw = data_write;
            prev_fa = fetch_addr;
            prev_da = data_addr;
            prev_wd = data_wdata;
        end
    end

    task automatic issue_fetch(input logic [31:0] a);
        logic [31:0] w;
        w = ref_read(a);
        fetch_addr = a;
        fetch_req  = 1'b1;
        fetch_q.push_back(a[1] ? w[31:16] : w[15:0]);
    endtask

    task automatic issue_data(input bit w, input logic [31:0] a, input logic [31:0] wd);
        data_write = w;
        data_addr  = a;
        data_wdata = wd;
        data_req   = 1'b1;
        if (w) begin
            ref_mem[a[12:2]] = wd;
            ref_wr[a[12:2]]  = 1'b1;
            data_q.push_back('{1'b1, 32'h0});
        end else begin
            data_q.push_back('{1'b0, ref_read(a)});
        end
    endtask

    task automatic wait_ready(input bit is_data);
        int n = 0;
        do begin
            @(posedge fast_clock); #1; n++;
        end while (!(is_data ? data_ready : fetch_ready) && n < 50);
        check(n < 50, "ready_timeout", n, 50);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || fetch_q.size() != 0 || data_q.size() != 0) && n < 100) begin
            @(posedge fast_clock); #1; n++;
        end
        check(n < 100, "idle_timeout", n, 100);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        repeat (2) @(posedge fast_clock);
        #1 reset = 1'b0;
    endtask

    task automatic contend(input int nd_want, input int nf_want);
        int dn = 0, fn = 0, n = 0;
        glog_owner.delete();
        glog_cyc.delete();
        for (int i = 0; i < nd_want; i++) issue_data(1'b0, 32'h20, 32'h0);
        for (int i = 0; i < nf_want; i++) issue_fetch(32'h1006);
        while ((dn < nd_want || fn < nf_want) && n < 200) begin
            @(posedge fast_clock); #1; n++;
            if (data_ready) begin dn++; if (dn == nd_want) data_req = 1'b0; end
            if (fetch_ready) begin fn++; if (fn == nf_want) fetch_req = 1'b0; end
        end
        check(n < 200, "contend_timeout", n, 200);
        wait_idle();
    endtask

    int exp_seq[$];
    int nf, nd, guard;

    initial begin
        reset = 1'b1;
        fetch_req = 1'b0; fetch_addr = '0;
        data_req = 1'b0; data_write = 1'b0; data_addr = '0; data_wdata = '0;
        repeat (3) @(posedge fast_clock);
        #1;
        check(outs_any() == 1'b0, "reset_state", {31'h0, outs_any()}, 32'h0);
        reset = 1'b0;
        @(posedge fast_clock); #1;

        issue_data(1'b1, 32'h100, 32'hBEEF1234);
        wait_ready(1'b1); data_req = 1'b0; wait_idle();
        issue_fetch(32'h102);
        wait_ready(1'b0); fetch_req = 1'b0; wait_idle();
        issue_data(1'b1, 32'h40, 32'h0000CAFE);
        wait_ready(1'b1); data_req = 1'b0; wait_idle();
        issue_data(1'b0, 32'h40, 32'h0);
        wait_ready(1'b1); data_req = 1'b0; wait_idle();

        pulse_reset();
        contend(1, 1);
        check(glog_owner.size() == 2, "simul_grants", glog_owner.size(), 2);
        if (glog_owner.size() == 2) begin
            check(glog_owner[0] == 1 && glog_owner[1] == 0, "simul_order",
                  {glog_owner[0][15:0], glog_owner[1][15:0]}, 32'h0001_0000);
            check(glog_cyc[1] - glog_cyc[0] == L + 2, "simul_spacing",
                  glog_cyc[1] - glog_cyc[0], L + 2);
        end

`ifdef ARBITER_ROUND_ROBIN_EN
        exp_seq = '{1, 0, 1, 0, 1, 0};
        contend(3, 3);
`else
        exp_seq = '{1, 1, 1, 0, 1};
        contend(4, 1);
`endif
        check(glog_owner.size() == exp_seq.size(), "contend_grants", glog_owner.size(), exp_seq.size());
        for (int i = 0; i < exp_seq.size() && i < glog_owner.size(); i++)
            check(glog_owner[i] == exp_seq[i], "contend_owner", glog_owner[i], exp_seq[i]);

        issue_data(1'b0, 32'h80, 32'h0);
        wait_ready(1'b1);
        @(posedge fast_clock); #2;
        reset = 1'b1;
        #1;
        check(outs_any() == 1'b0, "abort_outputs", {31'h0, outs_any()}, 32'h0);
        repeat (2) @(posedge fast_clock);
        #1 reset = 1'b0;
        issue_data(1'b0, 32'h80, 32'h0);
        wait_ready(1'b1); data_req = 1'b0; wait_idle();

        nf = 0; nd = 0; guard = 0;
        while ((nf < N_RAND || nd < N_RAND || fetch_req || data_req || busy ||
                fetch_q.size() != 0 || data_q.size() != 0) && guard < 20000) begin
            @(posedge fast_clock); #1; guard++;
            if (fetch_req && fetch_ready) fetch_req = 1'b0;
            if (data_req && data_ready) data_req = 1'b0;
            if (!fetch_req && nf < N_RAND && $urandom_range(0, 2) == 0) begin
                issue_fetch(32'h1000 + (32'($urandom_range(0, 255)) << 1));
                nf++;
            end
            if (!data_req && nd < N_RAND && $urandom_range(0, 2) == 0) begin
                issue_data(1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)) << 2, $urandom);
                nd++;
            end
        end
        check(guard < 20000, "random_timeout", guard, 20000);
        check(fetch_q.size() == 0 && data_q.size() == 0, "queues_drained",
              fetch_q.size() + data_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
